// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter fetch control block.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_adder.sv
// Sequential-path incrementer: pc_next = pc_current + 4, modulo 2^32.
module pc_adder
  import pc_pkg::*;
(
  input  logic [31:0] pc_current,
  output logic [31:0] pc_next
);

  assign pc_next = pc_current + PC_INC;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, next-PC select, boot delay, halt/resume FSM and fetch counter.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_target,
  input  logic               halt_i,
  input  logic               resume_i,
  output logic [31:0]        pc_current,
  output logic               pc_valid,
  output logic               halted,
  output logic               misalign_o,
  output logic [COUNT_W-1:0] instr_count
);

  localparam pc_state_t   StateInit = (BOOT_CYCLES == 0) ? RUN : BOOT;
  localparam logic [31:0] BootLast  = BOOT_CYCLES - 1;
  localparam logic [31:0] ResetPc   = RESET_VECTOR & PC_ALIGN_MASK;

  pc_state_t          state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        boot_cnt_q, boot_cnt_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               misalign_q, misalign_d;
  logic [31:0]        pc_seq;
  logic [31:0]        redirect_pc;
  logic               redirect_bad;

  pc_adder u_pc_adder (
    .pc_current (pc_q),
    .pc_next    (pc_seq)
  );

`ifdef PC_MISALIGN_TRAP_EN
  assign redirect_bad = (redirect_target[1:0] != 2'b00);
  assign redirect_pc  = redirect_bad ? (TRAP_VECTOR & PC_ALIGN_MASK) : redirect_target;
`else
  assign redirect_bad = 1'b0;
  assign redirect_pc  = redirect_target & PC_ALIGN_MASK;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    boot_cnt_d = boot_cnt_q;
    count_d    = count_q;
    misalign_d = 1'b0;
    unique case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 32'd1;
        if (boot_cnt_q == BootLast) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall_i && !halt_i && (count_q != {COUNT_W{1'b1}})) begin
          count_d = count_q + 1'b1;
        end
        if (halt_i) begin
          state_d = HALT;
        end else if (redirect_i) begin
          pc_d       = redirect_pc;
          misalign_d = redirect_bad;
        end else if (!stall_i) begin
          pc_d = pc_seq;
        end
      end
      HALT: begin
        if (redirect_i) begin
          pc_d       = redirect_pc;
          misalign_d = redirect_bad;
          state_d    = RUN;
        end else if (resume_i) begin
          pc_d    = pc_seq;
          state_d = RUN;
        end
      end
      default: state_d = StateInit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StateInit;
      pc_q       <= ResetPc;
      boot_cnt_q <= 32'd0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      boot_cnt_q <= boot_cnt_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_current  = pc_q;
  assign pc_valid    = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign misalign_o  = misalign_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl (default parameters).
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        halt_i = 1'b0;
  logic        resume_i = 1'b0;
  logic [31:0] pc_current;
  logic        pc_valid;
  logic        halted;
  logic        misalign_o;
  logic [31:0] instr_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_cnt = 32'd0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_target (redirect_target),
    .halt_i          (halt_i),
    .resume_i        (resume_i),
    .pc_current      (pc_current),
    .pc_valid        (pc_valid),
    .halted          (halted),
    .misalign_o      (misalign_o),
    .instr_count     (instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (pc_current !== 32'h0) begin $display("FAIL rst_pc got %h want 0", pc_current); n_err++; end
    n_cmp++; if (pc_valid !== 1'b0) begin $display("FAIL rst_valid got %b want 0", pc_valid); n_err++; end
    n_cmp++; if (halted !== 1'b0) begin $display("FAIL rst_halted got %b want 0", halted); n_err++; end
    n_cmp++; if (misalign_o !== 1'b0) begin $display("FAIL rst_misalign got %b want 0", misalign_o); n_err++; end
    n_cmp++; if (instr_count !== 32'h0) begin $display("FAIL rst_count got %0d want 0", instr_count); n_err++; end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (pc_valid !== 1'b0) begin $display("FAIL boot1_valid got %b want 0", pc_valid); n_err++; end
    tick();
    n_cmp++; if (pc_valid !== 1'b1) begin $display("FAIL boot_done_valid got %b want 1", pc_valid); n_err++; end
    n_cmp++; if (pc_current !== 32'h0) begin $display("FAIL first_pc got %h want 0", pc_current); n_err++; end
    n_cmp++; if (instr_count !== 32'd0) begin $display("FAIL first_count got %0d want 0", instr_count); n_err++; end
    for (int i = 1; i <= 2; i++) begin
      tick();
      exp_cnt = exp_cnt + 1;
      n_cmp++; if (pc_current !== 32'(4 * i)) begin $display("FAIL seq_pc got %h want %h", pc_current, 32'(4 * i)); n_err++; end
      n_cmp++; if (instr_count !== exp_cnt) begin $display("FAIL seq_count got %0d want %0d", instr_count, exp_cnt); n_err++; end
    end
  endtask

  task automatic test_stall();
    redirect_i = 1'b1; redirect_target = 32'h100;
    tick();
    redirect_i = 1'b0;
    exp_cnt = exp_cnt + 1;
    n_cmp++; if (pc_current !== 32'h100) begin $display("FAIL stall_setup_pc got %h want 100", pc_current); n_err++; end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (pc_current !== 32'h100) begin $display("FAIL stall_pc got %h want 100", pc_current); n_err++; end
      n_cmp++; if (instr_count !== exp_cnt) begin $display("FAIL stall_count got %0d want %0d", instr_count, exp_cnt); n_err++; end
    end
    stall_i = 1'b0;
    tick();
    exp_cnt = exp_cnt + 1;
    n_cmp++; if (pc_current !== 32'h104) begin $display("FAIL unstall_pc got %h want 104", pc_current); n_err++; end
    n_cmp++; if (instr_count !== exp_cnt) begin $display("FAIL unstall_count got %0d want %0d", instr_count, exp_cnt); n_err++; end
  endtask

  task automatic test_redirect_stall();
    redirect_i = 1'b1; redirect_target = 32'h10;
    tick();
    exp_cnt = exp_cnt + 1;
    n_cmp++; if (pc_current !== 32'h10) begin $display("FAIL rs_setup_pc got %h want 10", pc_current); n_err++; end
    stall_i = 1'b1; redirect_target = 32'h2000;
    tick();
    redirect_i = 1'b0; stall_i = 1'b0;
    n_cmp++; if (pc_current !== 32'h2000) begin $display("FAIL redir_over_stall_pc got %h want 2000", pc_current); n_err++; end
    n_cmp++; if (instr_count !== exp_cnt) begin $display("FAIL redir_stall_count got %0d want %0d", instr_count, exp_cnt); n_err++; end
  endtask

  task automatic test_halt();
    redirect_i = 1'b1; redirect_target = 32'h40;
    tick();
    redirect_i = 1'b0;
    exp_cnt = exp_cnt + 1;
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    n_cmp++; if (halted !== 1'b1) begin $display("FAIL halt_enter got %b want 1", halted); n_err++; end
    n_cmp++; if (pc_valid !== 1'b0) begin $display("FAIL halt_valid got %b want 0", pc_valid); n_err++; end
    for (int i = 0; i < 5; i++) begin
      stall_i = (i % 2) == 0;
      halt_i  = (i % 2) == 1;
      tick();
      n_cmp++; if (pc_current !== 32'h40 || halted !== 1'b1) begin
        $display("FAIL halt_hold pc=%h halted=%b want 40/1", pc_current, halted); n_err++; end
    end
    stall_i = 1'b0; halt_i = 1'b0; resume_i = 1'b1;
    tick();
    resume_i = 1'b0;
    n_cmp++; if (pc_current !== 32'h44) begin $display("FAIL resume_pc got %h want 44", pc_current); n_err++; end
    n_cmp++; if (halted !== 1'b0 || pc_valid !== 1'b1) begin
      $display("FAIL resume_state halted=%b valid=%b want 0/1", halted, pc_valid); n_err++; end
    n_cmp++; if (instr_count !== exp_cnt) begin $display("FAIL halt_count got %0d want %0d", instr_count, exp_cnt); n_err++; end
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    n_cmp++; if (pc_current !== 32'h44 || halted !== 1'b1) begin
      $display("FAIL halt2 pc=%h halted=%b want 44/1", pc_current, halted); n_err++; end
    redirect_i = 1'b1; resume_i = 1'b1; redirect_target = 32'h80;
    tick();
    redirect_i = 1'b0; resume_i = 1'b0;
    n_cmp++; if (pc_current !== 32'h80 || halted !== 1'b0) begin
      $display("FAIL halt_redirect pc=%h halted=%b want 80/0", pc_current, halted); n_err++; end
    tick();
    exp_cnt = exp_cnt + 1;
    n_cmp++; if (pc_current !== 32'h84) begin $display("FAIL post_halt_pc got %h want 84", pc_current); n_err++; end
    n_cmp++; if (instr_count !== exp_cnt) begin $display("FAIL post_halt_count got %0d want %0d", instr_count, exp_cnt); n_err++; end
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    exp_cnt = exp_cnt + 1;
    n_cmp++; if (pc_current !== 32'hFFFF_FFFC) begin $display("FAIL wrap_top got %h want fffffffc", pc_current); n_err++; end
    tick();
    exp_cnt = exp_cnt + 1;
    n_cmp++; if (pc_current !== 32'h0) begin $display("FAIL wrap_pc got %h want 0", pc_current); n_err++; end
    n_cmp++; if (instr_count !== exp_cnt) begin $display("FAIL wrap_count got %0d want %0d", instr_count, exp_cnt); n_err++; end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    logic        exp_mis;
`ifdef PC_MISALIGN_TRAP_EN
    exp_pc = 32'h100; exp_mis = 1'b1;
`else
    exp_pc = 32'h1000; exp_mis = 1'b0;
`endif
    redirect_i = 1'b1; redirect_target = 32'h1002;
    tick();
    redirect_i = 1'b0;
    n_cmp++; if (pc_current !== exp_pc) begin $display("FAIL misalign_pc got %h want %h", pc_current, exp_pc); n_err++; end
    n_cmp++; if (misalign_o !== exp_mis) begin $display("FAIL misalign_pulse got %b want %b", misalign_o, exp_mis); n_err++; end
    tick();
    n_cmp++; if (misalign_o !== 1'b0) begin $display("FAIL misalign_clear got %b want 0", misalign_o); n_err++; end
    n_cmp++; if (pc_current !== exp_pc + 32'd4) begin
      $display("FAIL misalign_next got %h want %h", pc_current, exp_pc + 32'd4); n_err++; end
  endtask

  task automatic test_reset_mid_halt();
    halt_i = 1'b1; redirect_target = 32'h3000;
    tick();
    n_cmp++; if (halted !== 1'b1) begin $display("FAIL rmh_halted got %b want 1", halted); n_err++; end
    redirect_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pc_current !== 32'h0 || halted !== 1'b0 || pc_valid !== 1'b0) begin
      $display("FAIL rmh_async pc=%h halted=%b valid=%b want 0/0/0", pc_current, halted, pc_valid); n_err++; end
    n_cmp++; if (instr_count !== 32'h0) begin $display("FAIL rmh_count got %0d want 0", instr_count); n_err++; end
    tick();
    halt_i = 1'b0; redirect_i = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++; if (pc_valid !== 1'b0 || pc_current !== 32'h0) begin
      $display("FAIL rmh_boot valid=%b pc=%h want 0/0", pc_valid, pc_current); n_err++; end
    tick();
    n_cmp++; if (pc_valid !== 1'b1 || pc_current !== 32'h0) begin
      $display("FAIL rmh_run valid=%b pc=%h want 1/0", pc_valid, pc_current); n_err++; end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_wrap();
    test_misalign();
    test_reset_mid_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
